// File: rtl/fpmul_pkg.sv
// fpmul_pkg: fp32 field widths, operand and tag types, and a one-hot helper
// shared by the multiplier scheduler and its arbiter.
package fpmul_pkg;

    localparam int FP32_W  = 32;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;

    // Largest requester count the scheduler is built for, and the matching id width.
    localparam int MAX_N   = 8;
    localparam int MAX_IDW = 3;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp32_t;

    // Travels alongside the core pipeline so each product can find its owner.
    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, id: '0};

    // One-hot decode of id, restricted to the first n positions.
    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDW-1:0] id, input int n);
        logic [MAX_N-1:0] vec;
        vec = '0;
        if (int'(id) < n) begin
            vec[id] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter. Searches from the pointer upward with
// wraparound, grants the first active request, and moves the pointer just
// past the winner so every requester is served within N cycles.
module rr_arbiter
    import fpmul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_idx
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;

    // Find the first requester at or after the pointer and compute the next pointer.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        ptr_d       = ptr_q;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDW'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
                ptr_d       = (cand == N - 1) ? '0 : IDW'(cand + 1);
            end
        end
    end

    // Turn the winning index into the one-hot grant vector.
    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant = N'(onehot(MAX_IDW'(grant_idx), N));
        end
    end

    // Pointer only advances when somebody actually won.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpmul_rr_sched.sv
// fpmul_rr_sched: shares one pipelined fp32 multiplier core among N requesters.
// One requester is granted per cycle; its operands are registered into the core
// while a {valid,id} tag walks a shift register in step with the core, so the
// product is returned to its originator 1 + MUL_LAT + 1 cycles after the grant.
module fpmul_rr_sched
    import fpmul_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [FP32_W*N-1:0] req_x,
    input  logic [FP32_W*N-1:0] req_y,
    output logic [FP32_W-1:0]   mul_x,
    output logic [FP32_W-1:0]   mul_y,
    input  logic [FP32_W-1:0]   mul_r,
    output logic [N-1:0]        rsp_valid,
    output logic [FP32_W-1:0]   rsp_r,
    output logic                busy,
    output logic [IDW+1:0]      inflight
);

    // Stage 0 sits beside mul_x/mul_y; the core needs one cycle to capture them
    // plus MUL_LAT cycles to produce the result, so the last stage lines up with mul_r.
    localparam int STAGES = MUL_LAT + 2;
    localparam int LAST   = STAGES - 1;
    localparam int CNT_W  = IDW + 2;

    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_idx;
    logic           xfer;

    fp32_t          sel_x;
    fp32_t          sel_y;

    fp32_t          mul_x_q, mul_x_d;
    fp32_t          mul_y_q, mul_y_d;
    tag_t           tag_q [STAGES];
    tag_t           tag_d [STAGES];
    logic [N-1:0]   rsp_valid_q, rsp_valid_d;
    logic [FP32_W-1:0] rsp_r_q, rsp_r_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic           busy_q, busy_d;

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // The grant is the handshake; reset forces it quiet so nothing is accepted.
    assign req_ready = rst ? '0 : grant;
    assign xfer      = grant_valid & ~rst;

    // One-hot AND-OR mux selecting the grantee's operand pair.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*FP32_W +: FP32_W];
                sel_y = req_y[i*FP32_W +: FP32_W];
            end
        end
    end

    // Issue: capture operands on a transfer, otherwise leave the core inputs alone.
    always_comb begin
        mul_x_d = xfer ? sel_x : mul_x_q;
        mul_y_d = xfer ? sel_y : mul_y_q;
    end

    // Tag pipeline: stage 0 records who was issued, later stages just shift.
    always_comb begin
        tag_d[0]                = TAG_IDLE;
        tag_d[0].valid          = xfer;
        tag_d[0].id[IDW-1:0]    = grant_idx;
        for (int j = 1; j < STAGES; j++) begin
            tag_d[j] = tag_q[j-1];
        end
    end

    // Return: route the core's product to the owner named by the oldest tag.
    always_comb begin
        rsp_valid_d = '0;
        if (tag_q[LAST].valid) begin
            rsp_valid_d = N'(onehot(tag_q[LAST].id, N));
        end
        rsp_r_d = mul_r;
    end

    // Outstanding count: +1 per transfer, -1 per product handed back.
    always_comb begin
        inflight_d = inflight_q + CNT_W'(xfer) - CNT_W'(tag_q[LAST].valid);
        busy_d     = (inflight_d != '0);
    end

    // All state; reset discards every in-flight tag so no response escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            for (int j = 0; j < STAGES; j++) begin
                tag_q[j] <= TAG_IDLE;
            end
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            inflight_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
        end
    end

    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign inflight  = inflight_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpmul_rr_sched.sv
// tb_fpmul_rr_sched: drives the scheduler with directed and random requests,
// emulates the shared multiplier core, and checks grants, returned products,
// response timing and the in-flight count against a simple behavioural model.
module tb_fpmul_rr_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 3;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [32*N-1:0]  req_x;
    logic [32*N-1:0]  req_y;
    logic [31:0]      mul_x;
    logic [31:0]      mul_y;
    logic [31:0]      mul_r;
    logic [N-1:0]     rsp_valid;
    logic [31:0]      rsp_r;
    logic             busy;
    logic [IDW+1:0]   inflight;

    typedef struct {
        int          id;
        logic [31:0] val;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    logic [N-1:0] pending;
    logic [N-1:0] cont;
    logic [N-1:0] xfer;
    logic [31:0] px [N];
    logic [31:0] py [N];
    logic [31:0] core_s1;

    fpmul_rr_sched #(
        .N       (N),
        .IDW     (IDW),
        .MUL_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_r     (mul_r),
        .rsp_valid (rsp_valid),
        .rsp_r     (rsp_r),
        .busy      (busy),
        .inflight  (inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Truncating fp32 multiply for normal numbers; a zero exponent reads as zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            return {s, e[7:0], p[46:24]};
        end
        return {s, e[7:0], p[45:23]};
    endfunction

    // Core stand-in: an input capture register followed by one result stage.
    always @(posedge clk) begin
        core_s1 <= fmul(mul_x, mul_y);
        mul_r   <= core_s1;
    end

    function automatic logic [31:0] randFp();
        logic [31:0] v;
        if ($urandom_range(0, 7) == 0) return 32'h0;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(64, 190));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic driveInputs();
        req_valid = pending;
        for (int i = 0; i < N; i++) begin
            req_x[i*32 +: 32] = px[i];
            req_y[i*32 +: 32] = py[i];
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] mask, input logic [N-1:0] keep,
                                 input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                pending[i] = 1'b1;
                cont[i]    = keep[i];
                px[i]      = x;
                py[i]      = y;
            end
        end
        driveInputs();
    endtask

    // Advance one cycle; retire accepted requests or refill continuous ones.
    task automatic stepCycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                if (cont[i]) begin
                    px[i] = randFp();
                    py[i] = randFp();
                end else begin
                    pending[i] = 1'b0;
                end
            end
        end
        driveInputs();
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n    = 0;
        cont = '0;
        while ((pending != '0 || sb.size() != 0) && n < limit) begin
            stepCycle();
            n++;
        end
        checkOutput("drain_done", 32'(pending != '0 || sb.size() != 0), 32'd0);
    endtask

    task automatic pulseReset(input int cycles);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        pending = '0;
        cont    = '0;
        driveInputs();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Arbitration model and scoreboard push: decide who should win this cycle.
    always @(negedge clk) begin
        logic [N-1:0] g;
        int           gi;
        g  = '0;
        gi = 0;
        if (rst) begin
            m_ptr = 0;
            xfer  = '0;
            checkOutput("req_ready_reset", 32'(req_ready), 32'd0);
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (pending[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            end
            if (pending != '0) g[gi] = 1'b1;
            checkOutput("req_ready", 32'(req_ready), 32'(g));
            if (pending != '0) begin
                sb.push_back('{id: gi, val: fmul(px[gi], py[gi]), issue: cyc + 1});
                m_ptr = (gi + 1) % N;
            end
            xfer = g;
        end
    end

    // Response monitor: each product must show up exactly LAT cycles after issue, in order.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            sb.delete();
            checkOutput("rsp_valid_reset", 32'(rsp_valid), 32'd0);
            checkOutput("rsp_r_reset", rsp_r, 32'd0);
            checkOutput("mul_x_reset", mul_x, 32'd0);
            checkOutput("mul_y_reset", mul_y, 32'd0);
            checkOutput("inflight_reset", 32'(inflight), 32'd0);
            checkOutput("busy_reset", 32'(busy), 32'd0);
        end else begin
            if (sb.size() != 0 && cyc - sb[0].issue >= LAT) begin
                e = sb.pop_front();
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
                checkOutput("rsp_r", rsp_r, e.val);
            end else begin
                checkOutput("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
            checkOutput("inflight", 32'(inflight), 32'(sb.size()));
            checkOutput("busy", 32'(busy), 32'(sb.size() != 0));
        end
    end

    initial begin
        rst     = 1'b1;
        pending = '0;
        cont    = '0;
        xfer    = '0;
        for (int i = 0; i < N; i++) begin
            px[i] = 32'h0;
            py[i] = 32'h0;
        end
        driveInputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single request on requester 2");
        applyStimulus(4'b0100, 4'b0000, 32'h3FC00000, 32'h40400000);
        waitDrain(20);

        $display("[TB] pointer wrap with requesters 3 and 0");
        applyStimulus(4'b1001, 4'b1001, 32'h3F800000, 32'h40000000);
        repeat (6) stepCycle();
        waitDrain(20);

        $display("[TB] zero operand on requester 1");
        applyStimulus(4'b0010, 4'b0000, 32'h00000000, 32'h40000000);
        waitDrain(20);

        $display("[TB] all four streaming from reset");
        pulseReset(2);
        applyStimulus(4'b1111, 4'b1111, 32'h40400000, 32'h3FC00000);
        repeat (12) stepCycle();
        waitDrain(20);

        $display("[TB] reset with products in flight");
        applyStimulus(4'b1111, 4'b1111, 32'h40800000, 32'h40A00000);
        repeat (6) stepCycle();
        pulseReset(2);
        applyStimulus(4'b1111, 4'b1111, 32'h3F000000, 32'h41000000);
        repeat (8) stepCycle();
        waitDrain(20);

        $display("[TB] random traffic");
        repeat (300) begin
            stepCycle();
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    pending[i] = 1'b1;
                    px[i]      = randFp();
                    py[i]      = randFp();
                end
            end
            driveInputs();
        end
        waitDrain(50);

        repeat (4) stepCycle();
        checkOutput("final_scoreboard", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
